// File: rtl/ace_snoop_arbiter.sv
// ACE snoop port arbiter: shares one cache snoop port (AC/CR/CD) between
// NumReq snoop sources, round-robin, one snoop outstanding at a time.
module ace_snoop_arbiter #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_ac_valid_i,
  output logic [NumReq-1:0]           req_ac_ready_o,
  input  logic [NumReq*AddrWidth-1:0] req_ac_addr_i,
  input  logic [NumReq*4-1:0]         req_ac_snoop_i,
  input  logic [NumReq*3-1:0]         req_ac_prot_i,
  output logic [NumReq-1:0]           req_cr_valid_o,
  input  logic [NumReq-1:0]           req_cr_ready_i,
  output logic [4:0]                  req_cr_resp_o,
  output logic [NumReq-1:0]           req_cd_valid_o,
  input  logic [NumReq-1:0]           req_cd_ready_i,
  output logic [DataWidth-1:0]        req_cd_data_o,
  output logic                        req_cd_last_o,
  output logic                        snoop_ac_valid_o,
  input  logic                        snoop_ac_ready_i,
  output logic [AddrWidth-1:0]        snoop_ac_addr_o,
  output logic [3:0]                  snoop_ac_snoop_o,
  output logic [2:0]                  snoop_ac_prot_o,
  input  logic                        snoop_cr_valid_i,
  output logic                        snoop_cr_ready_o,
  input  logic [4:0]                  snoop_cr_resp_i,
  input  logic                        snoop_cd_valid_i,
  output logic                        snoop_cd_ready_o,
  input  logic [DataWidth-1:0]        snoop_cd_data_i,
  input  logic                        snoop_cd_last_i,
  output logic                        busy_o,
  output logic [31:0]                 snoop_cnt_o,
  output logic [31:0]                 xfer_cnt_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {StIdle, StAc, StCr, StCd} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        owner_q, rr_q, winner, rr_next;
  logic [IdxW:0]          pos;
  logic                   found;
  logic                   hold_q;
  logic                   out_en, grant, cr_hs, cd_hs;
  logic [AddrWidth-1:0]   addr_q;
  logic [3:0]             snoop_q;
  logic [2:0]             prot_q;
  logic [31:0]            snoop_cnt_q, xfer_cnt_q;

  logic [AddrWidth-1:0]   addr_arr  [NumReq];
  logic [3:0]             snoop_arr [NumReq];
  logic [2:0]             prot_arr  [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_arr[g]  = req_ac_addr_i[g*AddrWidth +: AddrWidth];
    assign snoop_arr[g] = req_ac_snoop_i[g*4 +: 4];
    assign prot_arr[g]  = req_ac_prot_i[g*3 +: 3];
  end

  // Outputs stay quiet during reset and for the first cycle after it.
  assign out_en  = !rst_i && !hold_q;
  assign grant   = out_en && (state_q == StIdle) && found;
  assign cr_hs   = out_en && (state_q == StCr) && snoop_cr_valid_i && req_cr_ready_i[owner_q];
  assign cd_hs   = out_en && (state_q == StCd) && snoop_cd_valid_i && req_cd_ready_i[owner_q];
  assign rr_next = (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);

  // Round-robin search: first valid requester at or above rr_q, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    pos    = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = {1'b0, rr_q} + (IdxW+1)'(k);
      if (pos >= (IdxW+1)'(NumReq)) pos = pos - (IdxW+1)'(NumReq);
      if (!found && req_ac_valid_i[pos[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = pos[IdxW-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StAc;
      StAc:    if (snoop_ac_ready_i) state_d = StCr;
      StCr:    if (cr_hs) state_d = snoop_cr_resp_i[0] ? StCd : StIdle;
      StCd:    if (cd_hs && snoop_cd_last_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs: route the owner's channels, everything else held low.
  always_comb begin
    req_ac_ready_o   = '0;
    req_cr_valid_o   = '0;
    req_cr_resp_o    = '0;
    req_cd_valid_o   = '0;
    req_cd_data_o    = '0;
    req_cd_last_o    = 1'b0;
    snoop_ac_valid_o = 1'b0;
    snoop_cr_ready_o = 1'b0;
    snoop_cd_ready_o = 1'b0;
    if (out_en) begin
      unique case (state_q)
        StIdle: if (found) req_ac_ready_o[winner] = 1'b1;
        StAc:   snoop_ac_valid_o = 1'b1;
        StCr: begin
          req_cr_valid_o[owner_q] = snoop_cr_valid_i;
          req_cr_resp_o           = snoop_cr_resp_i;
          snoop_cr_ready_o        = req_cr_ready_i[owner_q];
        end
        StCd: begin
          req_cd_valid_o[owner_q] = snoop_cd_valid_i;
          req_cd_data_o           = snoop_cd_data_i;
          req_cd_last_o           = snoop_cd_last_i;
          snoop_cd_ready_o        = req_cd_ready_i[owner_q];
        end
        default: ;
      endcase
    end
  end

  // One-cycle post-reset hold-off.
  always_ff @(posedge clk_i) begin
    hold_q <= rst_i;
  end

  // Owner, round-robin pointer, latched AC payload and completion counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q     <= '0;
      rr_q        <= '0;
      addr_q      <= '0;
      snoop_q     <= '0;
      prot_q      <= '0;
      snoop_cnt_q <= '0;
      xfer_cnt_q  <= '0;
    end else begin
      if (grant) begin
        owner_q <= winner;
        rr_q    <= rr_next;
        addr_q  <= addr_arr[winner];
        snoop_q <= snoop_arr[winner];
        prot_q  <= prot_arr[winner];
      end
      if (cr_hs) begin
        snoop_cnt_q <= snoop_cnt_q + 32'd1;
        if (snoop_cr_resp_i[0]) xfer_cnt_q <= xfer_cnt_q + 32'd1;
      end
    end
  end

  assign snoop_ac_addr_o  = addr_q;
  assign snoop_ac_snoop_o = snoop_q;
  assign snoop_ac_prot_o  = prot_q;
  assign busy_o           = !rst_i && (state_q != StIdle);
  assign snoop_cnt_o      = snoop_cnt_q;
  assign xfer_cnt_o       = xfer_cnt_q;

endmodule

// File: tb/tb_ace_snoop_arbiter.sv
// Bench for ace_snoop_arbiter: a 2-requester instance driven as both snoop
// sources and cache, plus a 4-requester instance for wider round-robin.
module tb_ace_snoop_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---- 2-requester instance ----
  logic [1:0]   a_ac_valid, a_ac_ready, a_cr_valid, a_cr_ready, a_cd_valid, a_cd_ready;
  logic [127:0] a_ac_addr;
  logic [7:0]   a_ac_snoop;
  logic [5:0]   a_ac_prot;
  logic [4:0]   a_cr_resp, a_s_cr_resp;
  logic [63:0]  a_cd_data, a_s_cd_data, a_s_ac_addr;
  logic         a_cd_last, a_s_cd_last;
  logic         a_s_ac_valid, a_s_ac_ready, a_s_cr_valid, a_s_cr_ready, a_s_cd_valid, a_s_cd_ready;
  logic [3:0]   a_s_ac_snoop;
  logic [2:0]   a_s_ac_prot;
  logic         a_busy;
  logic [31:0]  a_snoop_cnt, a_xfer_cnt;

  ace_snoop_arbiter #(.NumReq(2), .AddrWidth(64), .DataWidth(64)) a_dut (
    .clk_i(clk), .rst_i(rst),
    .req_ac_valid_i(a_ac_valid), .req_ac_ready_o(a_ac_ready), .req_ac_addr_i(a_ac_addr),
    .req_ac_snoop_i(a_ac_snoop), .req_ac_prot_i(a_ac_prot),
    .req_cr_valid_o(a_cr_valid), .req_cr_ready_i(a_cr_ready), .req_cr_resp_o(a_cr_resp),
    .req_cd_valid_o(a_cd_valid), .req_cd_ready_i(a_cd_ready), .req_cd_data_o(a_cd_data),
    .req_cd_last_o(a_cd_last),
    .snoop_ac_valid_o(a_s_ac_valid), .snoop_ac_ready_i(a_s_ac_ready),
    .snoop_ac_addr_o(a_s_ac_addr), .snoop_ac_snoop_o(a_s_ac_snoop), .snoop_ac_prot_o(a_s_ac_prot),
    .snoop_cr_valid_i(a_s_cr_valid), .snoop_cr_ready_o(a_s_cr_ready),
    .snoop_cr_resp_i(a_s_cr_resp),
    .snoop_cd_valid_i(a_s_cd_valid), .snoop_cd_ready_o(a_s_cd_ready),
    .snoop_cd_data_i(a_s_cd_data), .snoop_cd_last_i(a_s_cd_last),
    .busy_o(a_busy), .snoop_cnt_o(a_snoop_cnt), .xfer_cnt_o(a_xfer_cnt)
  );

  // ---- 4-requester instance ----
  logic [3:0]   b_ac_valid, b_ac_ready, b_cr_valid, b_cr_ready, b_cd_valid, b_cd_ready;
  logic [127:0] b_ac_addr;
  logic [15:0]  b_ac_snoop;
  logic [11:0]  b_ac_prot;
  logic [4:0]   b_cr_resp, b_s_cr_resp;
  logic [31:0]  b_cd_data, b_s_cd_data, b_s_ac_addr;
  logic         b_cd_last, b_s_cd_last;
  logic         b_s_ac_valid, b_s_ac_ready, b_s_cr_valid, b_s_cr_ready, b_s_cd_valid, b_s_cd_ready;
  logic [3:0]   b_s_ac_snoop;
  logic [2:0]   b_s_ac_prot;
  logic         b_busy;
  logic [31:0]  b_snoop_cnt, b_xfer_cnt;

  ace_snoop_arbiter #(.NumReq(4), .AddrWidth(32), .DataWidth(32)) b_dut (
    .clk_i(clk), .rst_i(rst),
    .req_ac_valid_i(b_ac_valid), .req_ac_ready_o(b_ac_ready), .req_ac_addr_i(b_ac_addr),
    .req_ac_snoop_i(b_ac_snoop), .req_ac_prot_i(b_ac_prot),
    .req_cr_valid_o(b_cr_valid), .req_cr_ready_i(b_cr_ready), .req_cr_resp_o(b_cr_resp),
    .req_cd_valid_o(b_cd_valid), .req_cd_ready_i(b_cd_ready), .req_cd_data_o(b_cd_data),
    .req_cd_last_o(b_cd_last),
    .snoop_ac_valid_o(b_s_ac_valid), .snoop_ac_ready_i(b_s_ac_ready),
    .snoop_ac_addr_o(b_s_ac_addr), .snoop_ac_snoop_o(b_s_ac_snoop), .snoop_ac_prot_o(b_s_ac_prot),
    .snoop_cr_valid_i(b_s_cr_valid), .snoop_cr_ready_o(b_s_cr_ready),
    .snoop_cr_resp_i(b_s_cr_resp),
    .snoop_cd_valid_i(b_s_cd_valid), .snoop_cd_ready_o(b_s_cd_ready),
    .snoop_cd_data_i(b_s_cd_data), .snoop_cd_last_i(b_s_cd_last),
    .busy_o(b_busy), .snoop_cnt_o(b_snoop_cnt), .xfer_cnt_o(b_xfer_cnt)
  );

  // ---- reference model state ----
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] a_pay_addr [2];
  logic [3:0]  a_pay_snoop [2];
  logic [2:0]  a_pay_prot [2];
  int          a_rr;
  logic [31:0] a_m_snoop, a_m_xfer;
  logic [31:0] b_pay_addr [4];
  int          b_rr;
  logic [31:0] b_m_snoop;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_drive_req();
    for (int i = 0; i < 2; i++) begin
      a_ac_addr[i*64 +: 64] = a_pay_addr[i];
      a_ac_snoop[i*4 +: 4]  = a_pay_snoop[i];
      a_ac_prot[i*3 +: 3]   = a_pay_prot[i];
    end
  endtask

  task automatic a_new_req(input int i);
    a_pay_addr[i]  = {$urandom, $urandom};
    a_pay_snoop[i] = 4'($urandom);
    a_pay_prot[i]  = 3'($urandom);
    a_ac_valid[i]  = 1'b1;
  endtask

  task automatic a_cache_idle();
    a_s_ac_ready = 1'b0; a_s_cr_valid = 1'b0; a_s_cr_resp = '0;
    a_s_cd_valid = 1'b0; a_s_cd_data = '0; a_s_cd_last = 1'b0;
    a_cr_ready = '0; a_cd_ready = '0;
  endtask

  task automatic a_check_zero(input string tag);
    check_eq({tag, "_hs"}, {a_ac_ready, a_cr_valid, a_cd_valid, a_s_ac_valid,
                            a_s_cr_ready, a_s_cd_ready, a_busy}, 64'd0);
    check_eq({tag, "_cnt"}, {a_snoop_cnt, a_xfer_cnt}, 64'd0);
    check_eq({tag, "_addr"}, a_s_ac_addr, 64'd0);
    check_eq({tag, "_bus"}, {a_cr_resp, a_cd_last, a_s_ac_snoop, a_s_ac_prot, a_cd_data[31:0]},
             64'd0);
  endtask

  // One full snoop on the 2-requester instance. Entered and left just after a negedge.
  task automatic a_snoop(input logic [1:0] want, input logic [4:0] resp, input int nbeats,
                         input int ac_stall, input bit cd_stall, input int abort_beat,
                         output int won);
    int w, cyc, nst, crd, rdd, st;
    bit hs;
    logic [63:0] beat;
    for (int i = 0; i < 2; i++) if (want[i] && !a_ac_valid[i]) a_new_req(i);
    a_drive_req();
    w = -1;
    for (int k = 0; k < 2; k++) if (w < 0 && a_ac_valid[(a_rr + k) % 2]) w = (a_rr + k) % 2;
    won = w;
    #1;
    cyc = 0;
    while (a_ac_ready == 2'b00 && cyc < 8) begin @(negedge clk); #1; cyc++; end
    check_eq("ac_grant", a_ac_ready, 64'(1 << w));
    check_eq("ac_valid_pre", a_s_ac_valid, 64'd0);
    a_rr = (w + 1) % 2;
    @(posedge clk); #1;
    a_ac_valid[w] = 1'b0;
    // AC phase: payload held until the cache takes it.
    nst = (ac_stall < 0) ? int'($urandom_range(0, 2)) : ac_stall;
    for (int s = 0; s <= nst; s++) begin
      @(negedge clk);
      a_s_ac_ready = (s == nst); #1;
      check_eq("ac_valid", a_s_ac_valid, 64'd1);
      check_eq("ac_addr", a_s_ac_addr, a_pay_addr[w]);
      check_eq("ac_snoop_prot", {a_s_ac_snoop, a_s_ac_prot}, {a_pay_snoop[w], a_pay_prot[w]});
      check_eq("ac_ready_while_busy", {a_ac_ready, a_busy}, 64'd1);
    end
    // CR phase, with stray CD beats that must not be accepted.
    crd = $urandom_range(0, 2);
    rdd = $urandom_range(0, 2);
    hs = 1'b0;
    for (int c = 0; c < 8 && !hs; c++) begin
      @(negedge clk);
      a_cache_idle();
      a_s_cr_valid = (c >= crd);
      a_s_cr_resp  = a_s_cr_valid ? resp : 5'($urandom);
      a_cr_ready   = 2'($urandom);
      a_cr_ready[w] = (c >= rdd);
      a_s_cd_valid = 1'($urandom);
      a_s_cd_data  = {$urandom, $urandom};
      #1;
      check_eq("cr_valid", a_cr_valid, a_s_cr_valid ? 64'(1 << w) : 64'd0);
      check_eq("cr_resp", a_cr_resp, a_s_cr_resp);
      check_eq("cr_ready", a_s_cr_ready, a_cr_ready[w]);
      check_eq("cd_blocked_in_cr", {a_s_cd_ready, a_cd_valid, a_s_ac_valid}, 64'd0);
      hs = a_s_cr_valid && a_cr_ready[w];
    end
    check_eq("cr_handshake", hs, 64'd1);
    a_m_snoop = a_m_snoop + 32'd1;
    if (resp[0]) a_m_xfer = a_m_xfer + 32'd1;
    // CD phase.
    if (resp[0]) begin
      for (int b = 0; b < nbeats; b++) begin
        beat = {$urandom, $urandom};
        if (b == abort_beat) begin
          @(negedge clk);
          rst = 1'b1;
          a_cache_idle();
          @(negedge clk);
          rst = 1'b0;
          a_ac_valid = '0;
          a_new_req(0);
          a_new_req(1);
          a_drive_req();
          a_rr = 0; a_m_snoop = '0; a_m_xfer = '0;
          #1;
          a_check_zero("post_reset");
          return;
        end
        st = (cd_stall && b == 3) ? 3 : int'($urandom_range(0, 1));
        for (int c = 0; c <= st; c++) begin
          @(negedge clk);
          a_cache_idle();
          a_s_cd_valid = 1'b1;
          a_s_cd_data  = beat;
          a_s_cd_last  = (b == nbeats - 1);
          a_cd_ready   = 2'($urandom);
          a_cd_ready[w] = (c == st);
          #1;
          check_eq("cd_valid", a_cd_valid, 64'(1 << w));
          check_eq("cd_data", a_cd_data, beat);
          check_eq("cd_last", a_cd_last, 64'(b == nbeats - 1));
          check_eq("cd_ready", a_s_cd_ready, a_cd_ready[w]);
        end
      end
    end
    @(negedge clk);
    a_cache_idle();
    #1;
    check_eq("idle_after", a_busy, 64'd0);
    check_eq("snoop_cnt", a_snoop_cnt, a_m_snoop);
    check_eq("xfer_cnt", a_xfer_cnt, a_m_xfer);
  endtask

  task automatic b_drive_req();
    for (int i = 0; i < 4; i++) b_ac_addr[i*32 +: 32] = b_pay_addr[i];
  endtask

  // One snoop on the 4-requester instance; its cache side answers at once.
  task automatic b_snoop(input logic [3:0] want, output int won);
    int w, cyc;
    for (int i = 0; i < 4; i++) begin
      if (want[i] && !b_ac_valid[i]) begin
        b_pay_addr[i] = $urandom;
        b_ac_valid[i] = 1'b1;
      end
    end
    b_drive_req();
    w = -1;
    for (int k = 0; k < 4; k++) if (w < 0 && b_ac_valid[(b_rr + k) % 4]) w = (b_rr + k) % 4;
    won = w;
    #1;
    cyc = 0;
    while (b_ac_ready == 4'b0 && cyc < 8) begin @(negedge clk); #1; cyc++; end
    check_eq("b_grant", b_ac_ready, 64'(1 << w));
    b_rr = (w + 1) % 4;
    @(posedge clk); #1;
    b_ac_valid[w] = 1'b0;
    @(negedge clk); #1;
    check_eq("b_ac_addr", {b_s_ac_valid, b_s_ac_addr}, {31'd0, 1'b1, b_pay_addr[w]});
    cyc = 0;
    while (b_busy && cyc < 8) begin @(negedge clk); #1; cyc++; end
    check_eq("b_idle", b_busy, 64'd0);
    b_m_snoop = b_m_snoop + 32'd1;
    check_eq("b_snoop_cnt", b_snoop_cnt, b_m_snoop);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int won;
    int order [4];
    order = '{0, 1, 0, 1};
    rst = 1'b1;
    a_ac_valid = '0; a_ac_addr = '0; a_ac_snoop = '0; a_ac_prot = '0;
    for (int i = 0; i < 2; i++) begin a_pay_addr[i] = '0; a_pay_snoop[i] = '0; a_pay_prot[i] = '0; end
    a_cache_idle();
    a_rr = 0; a_m_snoop = '0; a_m_xfer = '0;
    b_ac_valid = '0; b_ac_addr = '0; b_ac_snoop = 16'h1234; b_ac_prot = 12'h5a5;
    for (int i = 0; i < 4; i++) b_pay_addr[i] = '0;
    b_s_ac_ready = 1'b1; b_s_cr_valid = 1'b1; b_s_cr_resp = '0; b_cr_ready = 4'hf;
    b_s_cd_valid = 1'b0; b_s_cd_data = '0; b_s_cd_last = 1'b0; b_cd_ready = '0;
    b_rr = 0; b_m_snoop = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    a_check_zero("reset");

    // Single ReadShared from req0, cache stalls AC for 2 cycles, no data.
    a_ac_valid[0] = 1'b1;
    a_pay_addr[0] = 64'h1000; a_pay_snoop[0] = 4'h1; a_pay_prot[0] = 3'h0;
    a_snoop(2'b01, 5'h00, 0, 2, 1'b0, -1, won);
    check_eq("first_owner", won, 64'd0);

    // Data-transfer snoop from req1: 8 beats with a 3-cycle ready stall.
    a_snoop(2'b10, 5'h01, 8, -1, 1'b1, -1, won);
    check_eq("burst_owner", won, 64'd1);

    // Both requesters contending: strict alternation.
    for (int k = 0; k < 4; k++) begin
      a_snoop(2'b11, 5'h00, 0, -1, 1'b0, -1, won);
      check_eq("rr_order", won, 64'(order[k]));
    end

    // Reset in the middle of a data burst, then a fresh grant goes to req0.
    a_snoop(2'b11, 5'h01, 8, -1, 1'b0, 4, won);
    a_snoop(2'b11, 5'h00, 0, -1, 1'b0, -1, won);
    check_eq("post_reset_owner", won, 64'd0);

    // Counter wrap from all-ones.
    force a_dut.snoop_cnt_q = 32'hffff_ffff;
    #1;
    release a_dut.snoop_cnt_q;
    a_m_snoop = 32'hffff_ffff;
    a_snoop(2'b01, 5'h02, 0, -1, 1'b0, -1, won);
    check_eq("cnt_wrapped", a_snoop_cnt, 64'd0);

    // Randomised traffic.
    for (int n = 0; n < 30; n++) begin
      a_snoop(2'($urandom_range(1, 3)), 5'($urandom), int'($urandom_range(1, 4)), -1,
              1'($urandom), -1, won);
    end

    // 4-requester instance from a fresh reset.
    @(negedge clk);
    a_ac_valid = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    a_rr = 0; b_rr = 0; b_m_snoop = '0;
    @(negedge clk);
    b_snoop(4'b0001, won);
    check_eq("b_first", won, 64'd0);
    b_snoop(4'b1000, won);
    check_eq("b_req3_from_rr1", won, 64'd3);
    b_snoop(4'b0111, won);
    check_eq("b_rr_wrapped", won, 64'd0);
    for (int n = 0; n < 20; n++) b_snoop(4'($urandom_range(1, 15)), won);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
